// File: rtl/clock_comp_rx.sv
// Receive-side clock compensation: buffers PCS blocks, drops alignment-marker slots
// and spends the bandwidth they free by inserting idles in front of incoming idles.
module clock_comp_rx #(
   parameter int  NB_DATA    = 66,
   parameter int  N_LANES    = 20,
   parameter int  NB_ADDR    = 6,
   parameter int  FILL_LEVEL = 20,
   parameter int  MAX_CREDIT = 2 * N_LANES,
   localparam int NB_CREDIT  = $clog2(MAX_CREDIT + 1)
) (
   // Stream ports carry no backpressure: i_valid qualifies i_data/i_am_tag in the
   // cycle it is high and is always accepted; o_valid qualifies o_data likewise.
   input  logic                 i_clock,
   input  logic                 i_reset_n,
   input  logic                 i_enable,
   input  logic                 i_valid,
   input  logic [NB_DATA-1:0]   i_data,
   input  logic                 i_am_tag,
   output logic [NB_DATA-1:0]   o_data,
   output logic                 o_valid,
   output logic                 o_underflow,
   output logic                 o_overflow,
   output logic [0:0]           o_dbg_state,
   output logic [NB_CREDIT-1:0] o_dbg_credit,
   output logic [NB_ADDR:0]     o_dbg_occupancy
);

   localparam int                 DEPTH    = 2 ** NB_ADDR;
   localparam logic [NB_ADDR:0]   DEPTH_L  = (NB_ADDR + 1)'(DEPTH);
   localparam logic [NB_ADDR:0]   FILL_L   = (NB_ADDR + 1)'(FILL_LEVEL);
   localparam logic [NB_CREDIT-1:0] MAX_L  = NB_CREDIT'(MAX_CREDIT);
   localparam logic [NB_DATA-1:0] PCS_IDLE = NB_DATA'(66'h1_e0_00_00_00_00_00_00_00);

   localparam logic [0:0] ST_FILL = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [NB_DATA-1:0]   mem [0:DEPTH-1];
   logic [NB_ADDR-1:0]   wr_ptr;
   logic [NB_ADDR-1:0]   rd_ptr;
   logic [NB_ADDR:0]     occupancy;
   logic [NB_CREDIT-1:0] credit;
   logic [0:0]           state;

   logic [NB_DATA-1:0] head;
   logic               full;
   logic               empty;
   logic               in_data;
   logic               in_tag;
   logic               run_act;
   logic               underflow;
   logic               insert;
   logic               pop;
   logic               push;
   logic               drop;

   assign head      = mem[rd_ptr];
   assign full      = (occupancy == DEPTH_L);
   assign empty     = (occupancy == '0);
   assign in_data   = i_enable && i_valid && !i_am_tag;
   assign in_tag    = i_enable && i_valid && i_am_tag;
   assign run_act   = i_enable && (state == ST_RUN);
   assign underflow = run_act && empty;
   // An idle at the head is held back while credit remains, so the inserted idles
   // always land directly in front of a real idle in the output stream.
   assign insert    = run_act && !empty && (head == PCS_IDLE) && (credit != '0);
   assign pop       = run_act && !empty && !insert;
   // A pop in the same cycle frees a slot, so a full FIFO still accepts the write.
   assign push      = in_data && (!full || pop);
   assign drop      = in_data && full && !pop;

   always_ff @(posedge i_clock) begin
      if (push) begin
         mem[wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   occupancy <= occupancy + 1'b1;
            2'b01:   occupancy <= occupancy - 1'b1;
            default: occupancy <= occupancy;
         endcase
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         credit <= '0;
      end else if (in_tag && insert) begin
         credit <= credit;
      end else if (in_tag && (credit < MAX_L)) begin
         credit <= credit + 1'b1;
      end else if (insert) begin
         credit <= credit - 1'b1;
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state <= ST_FILL;
      end else if (i_enable) begin
         case (state)
            ST_FILL: if (occupancy >= FILL_L) state <= ST_RUN;
            ST_RUN:  if (empty) state <= ST_FILL;
            default: state <= ST_FILL;
         endcase
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_data      <= PCS_IDLE;
         o_valid     <= 1'b0;
         o_underflow <= 1'b0;
         o_overflow  <= 1'b0;
      end else if (!i_enable) begin
         o_valid     <= 1'b0;
         o_underflow <= 1'b0;
         o_overflow  <= 1'b0;
      end else begin
         o_data      <= pop ? head : PCS_IDLE;
         o_valid     <= (state == ST_RUN);
         o_underflow <= underflow;
         o_overflow  <= drop;
      end
   end

   assign o_dbg_state     = state;
   assign o_dbg_credit    = credit;
   assign o_dbg_occupancy = occupancy;

endmodule

// File: tb/tb_clock_comp_rx.sv
// Directed bench for clock_comp_rx: a default instance plus one with FILL_LEVEL=64
// so the FIFO can be driven full before any block is popped.
module tb_clock_comp_rx;

   localparam logic [65:0] PCS_IDLE = 66'h1_e0_00_00_00_00_00_00_00;

   logic        clk = 1'b0;
   logic        i_reset_n = 1'b0;
   logic        i_enable = 1'b1;
   logic        i_valid = 1'b0;
   logic        i_am_tag = 1'b0;
   logic [65:0] i_data = '0;

   logic [65:0] o_data;
   logic        o_valid;
   logic        o_underflow;
   logic        o_overflow;
   logic [0:0]  dbg_state;
   logic [5:0]  dbg_credit;
   logic [6:0]  dbg_occ;

   logic [65:0] v_data;
   logic        v_valid;
   logic        v_underflow;
   logic        v_overflow;
   logic [0:0]  v_state;
   logic [5:0]  v_credit;
   logic [6:0]  v_occ;

   int          checks = 0;
   int          errors = 0;
   logic [65:0] exp_q[$];

   always #5 clk = ~clk;

   clock_comp_rx dut (
      .i_clock(clk), .i_reset_n(i_reset_n), .i_enable(i_enable), .i_valid(i_valid),
      .i_data(i_data), .i_am_tag(i_am_tag), .o_data(o_data), .o_valid(o_valid),
      .o_underflow(o_underflow), .o_overflow(o_overflow), .o_dbg_state(dbg_state),
      .o_dbg_credit(dbg_credit), .o_dbg_occupancy(dbg_occ)
   );

   clock_comp_rx #(.FILL_LEVEL(64)) dut_ovf (
      .i_clock(clk), .i_reset_n(i_reset_n), .i_enable(i_enable), .i_valid(i_valid),
      .i_data(i_data), .i_am_tag(i_am_tag), .o_data(v_data), .o_valid(v_valid),
      .o_underflow(v_underflow), .o_overflow(v_overflow), .o_dbg_state(v_state),
      .o_dbg_credit(v_credit), .o_dbg_occupancy(v_occ)
   );

   // Data blocks carry sync header 2'b10, so none can ever equal PCS_IDLE.
   function automatic logic [65:0] mk(input int k);
      return {2'b10, 32'hc0de_0000 + 32'(k), 32'(k) * 32'd3 + 32'd1};
   endfunction

   task automatic step(input logic v, input logic tag, input logic [65:0] d);
      i_valid  = v;
      i_am_tag = tag;
      i_data   = d;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset;
      i_reset_n = 1'b0;
      i_enable  = 1'b1;
      i_valid   = 1'b0;
      i_am_tag  = 1'b0;
      i_data    = '0;
      repeat (2) @(posedge clk);
      #1;
      i_reset_n = 1'b1;
   endtask

   task automatic test_reset;
      i_reset_n = 1'b0;
      i_valid   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (o_valid !== 1'b0 || o_underflow !== 1'b0 || o_overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags got v=%b u=%b o=%b exp 0 0 0", o_valid, o_underflow, o_overflow);
      end
      checks++;
      if (o_data !== PCS_IDLE) begin
         errors++;
         $display("FAIL reset_data got %h exp %h", o_data, PCS_IDLE);
      end
      checks++;
      if (dbg_state !== 1'b0 || dbg_credit !== 6'd0 || dbg_occ !== 7'd0) begin
         errors++;
         $display("FAIL reset_state got st=%0d cr=%0d occ=%0d exp 0 0 0", dbg_state, dbg_credit, dbg_occ);
      end
      i_reset_n = 1'b1;
      step(1'b0, 1'b0, '0);
      checks++;
      if (o_valid !== 1'b0 || dbg_state !== 1'b0) begin
         errors++;
         $display("FAIL reset_release got v=%b st=%0d exp 0 0", o_valid, dbg_state);
      end
   endtask

   task automatic test_fill_run;
      int bad_fill;
      apply_reset();
      bad_fill = 0;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b0, mk(i));
         if (o_valid !== 1'b0) bad_fill++;
      end
      checks++;
      if (bad_fill != 0) begin
         errors++;
         $display("FAIL fill_quiet got %0d valid cycles exp 0", bad_fill);
      end
      step(1'b0, 1'b0, '0);
      checks++;
      if (o_valid !== 1'b0 || dbg_state !== 1'b1) begin
         errors++;
         $display("FAIL fill_to_run got v=%b st=%0d exp 0 1", o_valid, dbg_state);
      end
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b0, '0);
         checks++;
         if (o_valid !== 1'b1 || o_data !== mk(i)) begin
            errors++;
            $display("FAIL fill_order[%0d] got v=%b %h exp 1 %h", i, o_valid, o_data, mk(i));
         end
      end
   endtask

   task automatic test_underflow;
      int extra_uf;
      int extra_v;
      apply_reset();
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0, mk(40 + i));
      repeat (21) step(1'b0, 1'b0, '0);
      checks++;
      if (o_valid !== 1'b1 || o_data !== mk(59)) begin
         errors++;
         $display("FAIL uf_last got v=%b %h exp 1 %h", o_valid, o_data, mk(59));
      end
      step(1'b0, 1'b0, '0);
      checks++;
      if (o_underflow !== 1'b1 || o_valid !== 1'b1 || o_data !== PCS_IDLE || dbg_state !== 1'b0) begin
         errors++;
         $display("FAIL uf_pulse got u=%b v=%b st=%0d %h exp 1 1 0 idle", o_underflow, o_valid, dbg_state, o_data);
      end
      extra_uf = 0;
      extra_v  = 0;
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0, '0);
         if (o_underflow !== 1'b0) extra_uf++;
         if (o_valid !== 1'b0) extra_v++;
      end
      checks++;
      if (extra_uf != 0 || extra_v != 0 || dbg_state !== 1'b0) begin
         errors++;
         $display("FAIL uf_after got uf=%0d v=%0d st=%0d exp 0 0 0", extra_uf, extra_v, dbg_state);
      end
   endtask

   task automatic test_idle_insert;
      logic [65:0] exp;
      apply_reset();
      exp_q.delete();
      for (int i = 0; i < 20; i++) exp_q.push_back(mk(i));
      exp_q.push_back(mk(200));
      for (int i = 0; i < 21; i++) exp_q.push_back(PCS_IDLE);
      exp_q.push_back(mk(201));
      for (int cyc = 1; cyc <= 65; cyc++) begin
         if (cyc <= 20)      step(1'b1, 1'b0, mk(cyc - 1));
         else if (cyc <= 40) step(1'b1, 1'b1, mk(100 + cyc));
         else if (cyc == 41) step(1'b1, 1'b0, mk(200));
         else if (cyc == 42) step(1'b1, 1'b0, PCS_IDLE);
         else if (cyc == 43) step(1'b1, 1'b0, mk(201));
         else                step(1'b0, 1'b0, '0);
         if (cyc == 21) begin
            checks++;
            if (o_valid !== 1'b0) begin
               errors++;
               $display("FAIL ins_first got v=%b exp 0", o_valid);
            end
         end
         if (cyc >= 22 && cyc <= 64) begin
            exp = exp_q.pop_front();
            checks++;
            if (o_valid !== 1'b1 || o_data !== exp) begin
               errors++;
               $display("FAIL ins_stream[%0d] got v=%b %h exp 1 %h", cyc, o_valid, o_data, exp);
            end
         end
         if (cyc == 40 || cyc == 42) begin
            checks++;
            if (dbg_credit !== 6'd20) begin
               errors++;
               $display("FAIL ins_credit20[%0d] got %0d exp 20", cyc, dbg_credit);
            end
         end
         if (cyc == 43) begin
            checks++;
            if (dbg_credit !== 6'd19) begin
               errors++;
               $display("FAIL ins_credit19 got %0d exp 19", dbg_credit);
            end
         end
         if (cyc == 62 || cyc == 64) begin
            checks++;
            if (dbg_credit !== 6'd0) begin
               errors++;
               $display("FAIL ins_credit0[%0d] got %0d exp 0", cyc, dbg_credit);
            end
         end
         if (cyc == 65) begin
            checks++;
            if (o_underflow !== 1'b1) begin
               errors++;
               $display("FAIL ins_drain got u=%b exp 1", o_underflow);
            end
         end
      end
   endtask

   task automatic test_overflow;
      logic [65:0] exp;
      int ovf_cnt;
      int early_v;
      apply_reset();
      exp_q.delete();
      for (int i = 0; i < 7; i++) exp_q.push_back(PCS_IDLE);
      for (int i = 1; i <= 63; i++) exp_q.push_back(mk(i));
      exp_q.push_back(mk(999));
      ovf_cnt = 0;
      early_v = 0;
      for (int cyc = 1; cyc <= 143; cyc++) begin
         if (cyc <= 6)       step(1'b1, 1'b1, mk(300 + cyc));
         else if (cyc == 7)  step(1'b1, 1'b0, PCS_IDLE);
         else if (cyc <= 76) step(1'b1, 1'b0, mk(cyc - 7));
         else if (cyc == 78) step(1'b1, 1'b0, mk(999));
         else                step(1'b0, 1'b0, '0);
         if (v_overflow === 1'b1) ovf_cnt++;
         if (cyc <= 71 && v_valid !== 1'b0) early_v++;
         if (cyc == 70) begin
            checks++;
            if (v_occ !== 7'd64) begin
               errors++;
               $display("FAIL ovf_full got occ=%0d exp 64", v_occ);
            end
         end
         if (cyc == 71) begin
            checks++;
            if (v_overflow !== 1'b1) begin
               errors++;
               $display("FAIL ovf_first got o=%b exp 1", v_overflow);
            end
         end
         if (cyc == 78) begin
            checks++;
            if (v_overflow !== 1'b0 || v_occ !== 7'd64) begin
               errors++;
               $display("FAIL ovf_push_pop got o=%b occ=%0d exp 0 64", v_overflow, v_occ);
            end
         end
         if (cyc >= 72 && cyc <= 142) begin
            exp = exp_q.pop_front();
            checks++;
            if (v_valid !== 1'b1 || v_data !== exp) begin
               errors++;
               $display("FAIL ovf_stream[%0d] got v=%b %h exp 1 %h", cyc, v_valid, v_data, exp);
            end
         end
         if (cyc == 143) begin
            checks++;
            if (v_underflow !== 1'b1) begin
               errors++;
               $display("FAIL ovf_drain got u=%b exp 1", v_underflow);
            end
         end
      end
      checks++;
      if (ovf_cnt != 6) begin
         errors++;
         $display("FAIL ovf_count got %0d exp 6", ovf_cnt);
      end
      checks++;
      if (early_v != 0) begin
         errors++;
         $display("FAIL ovf_held got %0d valid cycles exp 0", early_v);
      end
   endtask

   task automatic test_credit_sat;
      apply_reset();
      for (int cyc = 1; cyc <= 73; cyc++) begin
         if (cyc <= 50)      step(1'b1, 1'b1, mk(400 + cyc));
         else if (cyc == 51) step(1'b1, 1'b0, PCS_IDLE);
         else if (cyc <= 70) step(1'b1, 1'b0, mk(cyc));
         else if (cyc == 72) step(1'b1, 1'b1, mk(450));
         else                step(1'b0, 1'b0, '0);
         if (cyc == 40 || cyc == 50 || cyc == 71) begin
            checks++;
            if (dbg_credit !== 6'd40) begin
               errors++;
               $display("FAIL sat_credit[%0d] got %0d exp 40", cyc, dbg_credit);
            end
         end
         if (cyc == 70) begin
            checks++;
            if (dbg_state !== 1'b0 || o_valid !== 1'b0 || dbg_occ !== 7'd20) begin
               errors++;
               $display("FAIL sat_fill got st=%0d v=%b occ=%0d exp 0 0 20", dbg_state, o_valid, dbg_occ);
            end
         end
         if (cyc == 72) begin
            checks++;
            if (dbg_credit !== 6'd40 || o_valid !== 1'b1 || o_data !== PCS_IDLE || dbg_occ !== 7'd20) begin
               errors++;
               $display("FAIL sat_tag_insert got cr=%0d v=%b occ=%0d %h exp 40 1 20 idle", dbg_credit, o_valid, dbg_occ, o_data);
            end
         end
         if (cyc == 73) begin
            checks++;
            if (dbg_credit !== 6'd39) begin
               errors++;
               $display("FAIL sat_dec got %0d exp 39", dbg_credit);
            end
         end
      end
   endtask

   task automatic test_enable;
      apply_reset();
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0, mk(i));
      repeat (2) step(1'b0, 1'b0, '0);
      checks++;
      if (o_valid !== 1'b1 || o_data !== mk(0)) begin
         errors++;
         $display("FAIL en_first got v=%b %h exp 1 %h", o_valid, o_data, mk(0));
      end
      i_enable = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step(1'b1, (k == 1), mk(500 + k));
         checks++;
         if (o_valid !== 1'b0 || o_data !== mk(0) || dbg_occ !== 7'd19 || dbg_credit !== 6'd0 || dbg_state !== 1'b1) begin
            errors++;
            $display("FAIL en_freeze[%0d] got v=%b occ=%0d cr=%0d st=%0d %h exp 0 19 0 1 %h",
                     k, o_valid, dbg_occ, dbg_credit, dbg_state, o_data, mk(0));
         end
      end
      i_enable = 1'b1;
      for (int k = 1; k < 20; k++) begin
         step(1'b0, 1'b0, '0);
         checks++;
         if (o_valid !== 1'b1 || o_data !== mk(k)) begin
            errors++;
            $display("FAIL en_resume[%0d] got v=%b %h exp 1 %h", k, o_valid, o_data, mk(k));
         end
      end
   endtask

   task automatic test_reset_mid;
      apply_reset();
      for (int i = 0; i < 30; i++) step(1'b1, 1'b0, mk(600 + i));
      checks++;
      if (v_occ !== 7'd30 || o_valid !== 1'b1) begin
         errors++;
         $display("FAIL mid_pre got occ=%0d v=%b exp 30 1", v_occ, o_valid);
      end
      i_valid = 1'b0;
      #2;
      i_reset_n = 1'b0;
      #1;
      checks++;
      if (o_valid !== 1'b0 || o_data !== PCS_IDLE || o_underflow !== 1'b0 || o_overflow !== 1'b0) begin
         errors++;
         $display("FAIL mid_outputs got v=%b u=%b o=%b %h exp 0 0 0 idle", o_valid, o_underflow, o_overflow, o_data);
      end
      checks++;
      if (dbg_occ !== 7'd0 || v_occ !== 7'd0 || dbg_credit !== 6'd0 || dbg_state !== 1'b0) begin
         errors++;
         $display("FAIL mid_state got occ=%0d vocc=%0d cr=%0d st=%0d exp 0 0 0 0", dbg_occ, v_occ, dbg_credit, dbg_state);
      end
      @(posedge clk);
      #1;
      i_reset_n = 1'b1;
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0, mk(700 + i));
      step(1'b0, 1'b0, '0);
      checks++;
      if (o_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_refill got v=%b exp 0", o_valid);
      end
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b0, '0);
         checks++;
         if (o_valid !== 1'b1 || o_data !== mk(700 + i)) begin
            errors++;
            $display("FAIL mid_new[%0d] got v=%b %h exp 1 %h", i, o_valid, o_data, mk(700 + i));
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_fill_run();
      test_underflow();
      test_idle_insert();
      test_overflow();
      test_credit_sat();
      test_enable();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
